// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: owner IDs and arbiter state.
package sdram_arb_pkg;

  localparam logic OWNER_ABUS = 1'b0;
  localparam logic OWNER_CPU  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Small synchronous FIFO holding the issuing-port ID of each outstanding read.
module sdram_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == CNT_W'(0));
    head_o   = mem_q[rd_ptr_q];
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller Avalon-MM slave between the A-bus bridge (port 0)
// and the CPU/DMA master (port 1), steering read returns back by issue order.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan_rdv
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;

  logic req1, elig0, elig1;
  logic has_owner, owner, grant;
  logic own_read, own_write, accepted;
  logic fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;

  // Arbitration and next state; a read counts as eligible only with FIFO room.
  always_comb begin
    req1      = m1_read | m1_write;
    elig0     = m0_read ? ~fifo_full : m0_write;
    elig1     = m1_read ? ~fifo_full : m1_write;
    has_owner = 1'b0;
    owner     = OWNER_ABUS;
    state_d   = state_q;
    owner_d   = owner_q;
    case (state_q)
      IDLE: begin
        if (elig1 && ((starve_q == STARVE_MAX) || !elig0)) begin
          has_owner = 1'b1;
          owner     = OWNER_CPU;
        end else if (elig0) begin
          has_owner = 1'b1;
          owner     = OWNER_ABUS;
        end else begin
          has_owner = 1'b0;
          owner     = OWNER_ABUS;
        end
        if (has_owner && s_waitrequest) begin
          state_d = HOLD;
          owner_d = owner;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        has_owner = 1'b1;
        owner     = owner_q;
        if (!s_waitrequest) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command mux; reset blanks the bus combinationally so it takes effect at once.
  always_comb begin
    grant          = has_owner & ~reset;
    own_read       = (owner == OWNER_CPU) ? m1_read : m0_read;
    own_write      = (owner == OWNER_CPU) ? m1_write : m0_write;
    s_read         = grant & own_read;
    s_write        = grant & own_write & ~own_read;
    s_address      = (owner == OWNER_CPU) ? m1_address : m0_address;
    s_writedata    = (owner == OWNER_CPU) ? m1_writedata : m0_writedata;
    s_byteenable   = (owner == OWNER_CPU) ? m1_byteenable : m0_byteenable;
    m0_waitrequest = ~(grant && (owner == OWNER_ABUS)) | s_waitrequest;
    m1_waitrequest = ~(grant && (owner == OWNER_CPU)) | s_waitrequest;
    accepted       = grant & ~s_waitrequest;
    fifo_push      = accepted & s_read;
  end

  // Starvation counter and read-return steering.
  always_comb begin
    if (req1 && !(accepted && (owner == OWNER_CPU))) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : (starve_q + STARVE_W'(1));
    end else begin
      starve_d = STARVE_W'(0);
    end
    fifo_pop         = s_readdatavalid & ~fifo_empty & ~reset;
    m0_readdatavalid = fifo_pop & (fifo_head == OWNER_ABUS);
    m1_readdatavalid = fifo_pop & (fifo_head == OWNER_CPU);
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    err_d            = err_q | (s_readdatavalid & fifo_empty);
    err_orphan_rdv   = err_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_ABUS;
      starve_q <= STARVE_W'(0);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (owner),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: inputs change on the falling edge and
// combinational outputs are checked 1 ns later, well away from the rising edge.
module tb_sdram_port_arbiter;

  logic        clock;
  logic        reset;
  logic [23:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic        err_orphan_rdv;

  int n_checks = 0;
  int n_errors = 0;

  sdram_port_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .err_orphan_rdv   (err_orphan_rdv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [23:0] a, input logic [15:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [23:0] a, input logic [15:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
  endtask

  task automatic ret(input logic v, input logic [15:0] d);
    s_readdatavalid = v; s_readdata = d;
  endtask

  initial begin
    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 24'h000001, 16'h0000);
    drive_m1(1'b0, 1'b1, 24'h000002, 16'h0000);
    m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0;
    ret(1'b1, 16'h1111);

    // Reset: bus blanked even with requests and a return present.
    @(negedge clock); #1;
    check("rst_s_read", s_read, 1'b0);
    check("rst_s_write", s_write, 1'b0);
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("rst_err", err_orphan_rdv, 1'b0);

    @(negedge clock);
    reset = 1'b0;
    drive_m0(1'b0, 1'b0, 24'h0, 16'h0);
    drive_m1(1'b0, 1'b0, 24'h0, 16'h0);
    ret(1'b0, 16'h0);
    #1;
    check("idle_m0_wait", m0_waitrequest, 1'b1);
    check("idle_err", err_orphan_rdv, 1'b0);

    // Port 0 single read, data back three cycles later.
    @(negedge clock);
    drive_m0(1'b1, 1'b0, 24'h000123, 16'h0);
    #1;
    check("t1_s_read", s_read, 1'b1);
    check("t1_s_addr", s_address, 24'h000123);
    check("t1_m0_wait", m0_waitrequest, 1'b0);
    @(negedge clock); drive_m0(1'b0, 1'b0, 24'h0, 16'h0);
    @(negedge clock);
    @(negedge clock); ret(1'b1, 16'hBEEF); #1;
    check("t1_m0_rdv", m0_readdatavalid, 1'b1);
    check("t1_m0_data", m0_readdata, 16'hBEEF);
    check("t1_m1_rdv", m1_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b0, 16'h0);

    // m0 write and m1 read together: m0 first, m1 next cycle.
    @(negedge clock);
    drive_m0(1'b0, 1'b1, 24'h000010, 16'h5A5A); m0_byteenable = 2'b01;
    drive_m1(1'b1, 1'b0, 24'h000020, 16'h0);
    #1;
    check("t2_s_write", s_write, 1'b1);
    check("t2_s_read", s_read, 1'b0);
    check("t2_addr0", s_address, 24'h000010);
    check("t2_wdata", s_writedata, 16'h5A5A);
    check("t2_be", s_byteenable, 2'b01);
    check("t2_m1_wait", m1_waitrequest, 1'b1);
    @(negedge clock);
    drive_m0(1'b0, 1'b0, 24'h0, 16'h0); m0_byteenable = 2'b11;
    #1;
    check("t2_s_read1", s_read, 1'b1);
    check("t2_addr1", s_address, 24'h000020);
    check("t2_m1_wait1", m1_waitrequest, 1'b0);
    @(negedge clock); drive_m1(1'b0, 1'b0, 24'h0, 16'h0); ret(1'b1, 16'h1234); #1;
    check("t2_m1_rdv", m1_readdatavalid, 1'b1);
    check("t2_m1_data", m1_readdata, 16'h1234);
    check("t2_m0_rdv", m0_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b0, 16'h0);

    // m1 owns a stalled read for 5 cycles while m0 requests.
    @(negedge clock);
    drive_m1(1'b1, 1'b0, 24'h000030, 16'h0);
    s_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clock);
      if (i == 1) drive_m0(1'b1, 1'b0, 24'h000040, 16'h0);
      #1;
      check("t3_hold_addr", s_address, 24'h000030);
      check("t3_hold_m0_wait", m0_waitrequest, 1'b1);
    end
    @(negedge clock); s_waitrequest = 1'b0; #1;
    check("t3_rel_addr", s_address, 24'h000030);
    check("t3_rel_m1_wait", m1_waitrequest, 1'b0);
    check("t3_rel_m0_wait", m0_waitrequest, 1'b1);
    @(negedge clock); drive_m1(1'b0, 1'b0, 24'h0, 16'h0); #1;
    check("t3_m0_addr", s_address, 24'h000040);
    check("t3_m0_wait", m0_waitrequest, 1'b0);
    @(negedge clock); drive_m0(1'b0, 1'b0, 24'h0, 16'h0); ret(1'b1, 16'h3030); #1;
    check("t3_ret1_m1", m1_readdatavalid, 1'b1);
    check("t3_ret1_m0", m0_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b1, 16'h4040); #1;
    check("t3_ret2_m0", m0_readdatavalid, 1'b1);
    check("t3_ret2_m1", m1_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b0, 16'h0);

    // Starvation: both write continuously, m1 wins on the 9th cycle.
    @(negedge clock);
    drive_m0(1'b0, 1'b1, 24'h000100, 16'h0001);
    drive_m1(1'b0, 1'b1, 24'h000200, 16'h0002);
    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      check("t4_addr", s_address, (i == 8) ? 24'h000200 : 24'h000100);
      check("t4_m1_wait", m1_waitrequest, (i == 8) ? 1'b0 : 1'b1);
    end
    @(negedge clock);
    drive_m0(1'b0, 1'b0, 24'h0, 16'h0);
    drive_m1(1'b0, 1'b0, 24'h0, 16'h0);

    // Fill the tag FIFO with interleaved reads.
    @(negedge clock); drive_m0(1'b1, 1'b0, 24'h000400, 16'h0); #1;
    check("t5_r0", s_address, 24'h000400);
    @(negedge clock); drive_m0(1'b0, 1'b0, 24'h0, 16'h0); drive_m1(1'b1, 1'b0, 24'h000401, 16'h0); #1;
    check("t5_r1", s_address, 24'h000401);
    @(negedge clock); drive_m1(1'b0, 1'b0, 24'h0, 16'h0); drive_m0(1'b1, 1'b0, 24'h000402, 16'h0); #1;
    check("t5_r2", s_address, 24'h000402);
    @(negedge clock); drive_m0(1'b0, 1'b0, 24'h0, 16'h0); drive_m1(1'b1, 1'b0, 24'h000403, 16'h0); #1;
    check("t5_r3_wait", m1_waitrequest, 1'b0);
    @(negedge clock);
    drive_m0(1'b1, 1'b0, 24'h000404, 16'h0);
    drive_m1(1'b0, 1'b1, 24'h000500, 16'h0F0F);
    #1;
    check("t5_full_m0_wait", m0_waitrequest, 1'b1);
    check("t5_full_s_read", s_read, 1'b0);
    check("t5_full_s_write", s_write, 1'b1);
    check("t5_full_waddr", s_address, 24'h000500);
    check("t5_full_m1_wait", m1_waitrequest, 1'b0);
    @(negedge clock); drive_m1(1'b0, 1'b0, 24'h0, 16'h0); ret(1'b1, 16'hA000); #1;
    check("t5_ret0_m0", m0_readdatavalid, 1'b1);
    check("t5_ret0_data", m0_readdata, 16'hA000);
    check("t5_ret0_m0_wait", m0_waitrequest, 1'b1);
    @(negedge clock); ret(1'b1, 16'hA001); #1;
    check("t5_ret1_m1", m1_readdatavalid, 1'b1);
    check("t5_r4_wait", m0_waitrequest, 1'b0);
    check("t5_r4_addr", s_address, 24'h000404);
    @(negedge clock); drive_m0(1'b0, 1'b0, 24'h0, 16'h0); ret(1'b1, 16'hA002); #1;
    check("t5_ret2_m0", m0_readdatavalid, 1'b1);
    @(negedge clock); ret(1'b1, 16'hA003); #1;
    check("t5_ret3_m1", m1_readdatavalid, 1'b1);
    check("t5_ret3_m0", m0_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b1, 16'hA004); #1;
    check("t5_ret4_m0", m0_readdatavalid, 1'b1);
    check("t5_err_clean", err_orphan_rdv, 1'b0);

    // Orphan return: flagged and sticky.
    @(negedge clock); ret(1'b1, 16'hDEAD); #1;
    check("t6_orph_m0", m0_readdatavalid, 1'b0);
    check("t6_orph_m1", m1_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b0, 16'h0); #1;
    check("t6_err_set", err_orphan_rdv, 1'b1);
    repeat (3) @(negedge clock);
    #1;
    check("t6_err_sticky", err_orphan_rdv, 1'b1);

    // Reset in the middle of a HOLD with a read outstanding.
    @(negedge clock); drive_m1(1'b1, 1'b0, 24'h000600, 16'h0); #1;
    check("t7_m1_acc", m1_waitrequest, 1'b0);
    @(negedge clock);
    drive_m1(1'b0, 1'b0, 24'h0, 16'h0);
    drive_m0(1'b1, 1'b0, 24'h000700, 16'h0);
    s_waitrequest = 1'b1;
    @(negedge clock); #1;
    check("t7_hold_addr", s_address, 24'h000700);
    check("t7_hold_read", s_read, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("t7_rst_s_read", s_read, 1'b0);
    check("t7_rst_m0_wait", m0_waitrequest, 1'b1);
    check("t7_rst_m1_wait", m1_waitrequest, 1'b1);
    check("t7_rst_err", err_orphan_rdv, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive_m0(1'b0, 1'b0, 24'h0, 16'h0);
    s_waitrequest = 1'b0;
    @(negedge clock); ret(1'b1, 16'h6060); #1;
    check("t7_late_m1", m1_readdatavalid, 1'b0);
    check("t7_late_m0", m0_readdatavalid, 1'b0);
    @(negedge clock); ret(1'b0, 16'h0); #1;
    check("t7_late_err", err_orphan_rdv, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
